// File: rtl/out_port_bcd_conv.sv
// Sequential binary-to-BCD converter for the CPU output port display.
// Optional leading-zero blanking output enabled by OUT_PORT_BCD_BLANK_EN.
module out_port_bcd_conv #(
  parameter int DATA_W = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic [DATA_W-1:0]     din,
  input  logic                  start,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf
`ifdef OUT_PORT_BCD_BLANK_EN
  ,
  output logic [DIGITS-1:0]     blank
`endif
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(DATA_W + 1);

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) begin
      p = p * 64'd10;
    end
    return p;
  endfunction

  localparam logic [63:0]   LIMIT = pow10(DIGITS);
  localparam logic [BW-1:0] ALL9  = {DIGITS{4'h9}};

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] last;
  logic [DATA_W-1:0] shreg;
  logic [BW-1:0]     work;
  logic [CW-1:0]     cnt;

  logic [BW-1:0]     adj;
  logic [BW-1:0]     work_nxt;
  logic              trigger;
  logic              over;

  // Add-3 correction on every work digit of 5 or more.
  always_comb begin
    adj = work;
    for (int k = 0; k < DIGITS; k++) begin
      if (work[4*k +: 4] >= 4'd5) begin
        adj[4*k +: 4] = work[4*k +: 4] + 4'd3;
      end
    end
  end

  // Shift the corrected digits left, pulling in the next binary bit.
  always_comb begin
    work_nxt = (adj << 1) | {{(BW-1){1'b0}}, shreg[DATA_W-1]};
  end

  // Start conditions and overflow of the captured value.
  always_comb begin
    trigger = start || (din != last);
    over    = ({{(64-DATA_W){1'b0}}, last} >= LIMIT);
  end

`ifdef OUT_PORT_BCD_BLANK_EN
  logic [DIGITS-1:0] blank_nxt;

  // Flag zero digits above the most significant nonzero one.
  always_comb begin
    logic lead;
    lead      = 1'b1;
    blank_nxt = '0;
    for (int k = DIGITS - 1; k > 0; k--) begin
      if (work_nxt[4*k +: 4] != 4'd0) begin
        lead = 1'b0;
      end
      blank_nxt[k] = lead;
    end
  end
`endif

  // Conversion FSM; results land on the last shift so they show in DONE.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      last  <= '0;
      shreg <= '0;
      work  <= '0;
      cnt   <= '0;
      bcd   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      ovf   <= 1'b0;
`ifdef OUT_PORT_BCD_BLANK_EN
      blank <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (trigger) begin
            shreg <= din;
            last  <= din;
            work  <= '0;
            cnt   <= CW'(DATA_W);
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          work  <= work_nxt;
          shreg <= shreg << 1;
          cnt   <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            bcd   <= over ? ALL9 : work_nxt;
            ovf   <= over;
`ifdef OUT_PORT_BCD_BLANK_EN
            blank <= over ? '0 : blank_nxt;
`endif
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_out_port_bcd_conv.sv
// Scoreboard bench for out_port_bcd_conv: a 3-digit and a 2-digit instance.
// Blank output is checked when OUT_PORT_BCD_BLANK_EN is defined.
module tb_out_port_bcd_conv;

  typedef struct {
    logic [11:0] b;
    logic        o;
    logic [2:0]  bl;
  } exp_t;

  logic        clock;
  logic        resetn;
  logic [7:0]  din3, din2;
  logic        start3, start2;
  logic [11:0] bcd3;
  logic [7:0]  bcd2;
  logic        busy3, done3, ovf3;
  logic        busy2, done2, ovf2;
`ifdef OUT_PORT_BCD_BLANK_EN
  logic [2:0]  blank3;
  logic [1:0]  blank2;
`endif

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int done_cyc = 0;
  int c0;
  exp_t q3[$];
  exp_t q2[$];

  out_port_bcd_conv #(.DATA_W(8), .DIGITS(3)) dut3 (
    .clock(clock), .resetn(resetn), .din(din3), .start(start3),
    .bcd(bcd3), .busy(busy3), .done(done3), .ovf(ovf3)
`ifdef OUT_PORT_BCD_BLANK_EN
    , .blank(blank3)
`endif
  );

  out_port_bcd_conv #(.DATA_W(8), .DIGITS(2)) dut2 (
    .clock(clock), .resetn(resetn), .din(din2), .start(start2),
    .bcd(bcd2), .busy(busy2), .done(done2), .ovf(ovf2)
`ifdef OUT_PORT_BCD_BLANK_EN
    , .blank(blank2)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic [11:0] b, input logic o,
                              input logic [2:0] bl);
    exp_t e;
    e.b  = b;
    e.o  = o;
    e.bl = bl;
    return e;
  endfunction

  // Monitor: pop and compare on every done pulse.
  always @(negedge clock) begin
    exp_t e;
    if (done3) begin
      done_cyc = cyc;
      if (q3.size() == 0) begin
        chk("unexpected_done3", {52'd0, bcd3}, 64'hFFFF);
      end else begin
        e = q3.pop_front();
        chk("bcd3", {52'd0, bcd3}, {52'd0, e.b});
        chk("ovf3", {63'd0, ovf3}, {63'd0, e.o});
`ifdef OUT_PORT_BCD_BLANK_EN
        chk("blank3", {61'd0, blank3}, {61'd0, e.bl});
`endif
      end
      if (busy3) chk("busy_done3", 64'd1, 64'd0);
    end
    if (done2) begin
      if (q2.size() == 0) begin
        chk("unexpected_done2", {56'd0, bcd2}, 64'hFFFF);
      end else begin
        e = q2.pop_front();
        chk("bcd2", {56'd0, bcd2}, {56'd0, e.b[7:0]});
        chk("ovf2", {63'd0, ovf2}, {63'd0, e.o});
`ifdef OUT_PORT_BCD_BLANK_EN
        chk("blank2", {62'd0, blank2}, {62'd0, e.bl[1:0]});
`endif
      end
      if (busy2) chk("busy_done2", 64'd1, 64'd0);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while ((q3.size() != 0 || q2.size() != 0) && k < 100) begin
      step(1);
      k++;
    end
    if (q3.size() != 0 || q2.size() != 0) begin
      chk({"timeout_", name}, 64'(q3.size() + q2.size()), 64'd0);
      q3.delete();
      q2.delete();
    end
    step(3);
  endtask

  task automatic chk_reset(input string name);
    chk({name, "_bcd"}, {52'd0, bcd3}, 64'd0);
    chk({name, "_busy"}, {63'd0, busy3}, 64'd0);
    chk({name, "_done"}, {63'd0, done3}, 64'd0);
    chk({name, "_ovf"}, {63'd0, ovf3}, 64'd0);
  endtask

  initial begin
    resetn = 1'b0;
    din3   = 8'd0;
    din2   = 8'd0;
    start3 = 1'b0;
    start2 = 1'b0;
    step(3);
    @(negedge clock);
    chk_reset("rst");
    step(1);
    resetn = 1'b1;
    step(12);
    chk("idle_din0_busy", {63'd0, busy3}, 64'd0);

    // 255: latency and busy timing
    q3.push_back(mk(12'h255, 1'b0, 3'b000));
    din3 = 8'd255;
    c0 = cyc;
    @(posedge clock);
    @(negedge clock);
    chk("busy_after_trig", {63'd0, busy3}, 64'd1);
    drain("255");
    chk("lat255", 64'(done_cyc - c0), 64'd9);
    step(15);

    // 99 then 100 mid-conversion
    q3.push_back(mk(12'h099, 1'b0, 3'b100));
    q3.push_back(mk(12'h100, 1'b0, 3'b000));
    din3 = 8'd99;
    c0 = cyc;
    step(3);
    din3 = 8'd100;
    drain("99_100");
    chk("lat100", 64'(done_cyc - c0), 64'd19);

    // two-digit instance with overflow
    q2.push_back(mk(12'h099, 1'b1, 3'b000));
    din2 = 8'd100;
    drain("d2_100");
    q2.push_back(mk(12'h042, 1'b0, 3'b000));
    din2 = 8'd42;
    drain("d2_42");
    q2.push_back(mk(12'h099, 1'b0, 3'b000));
    din2 = 8'd99;
    drain("d2_99");
    q2.push_back(mk(12'h005, 1'b0, 3'b010));
    din2 = 8'd5;
    drain("d2_5");
    q2.push_back(mk(12'h000, 1'b0, 3'b010));
    din2 = 8'd0;
    drain("d2_0");

    // start forces reconversion; start while busy ignored
    q3.push_back(mk(12'h037, 1'b0, 3'b100));
    din3 = 8'd37;
    drain("37");
    q3.push_back(mk(12'h037, 1'b0, 3'b100));
    start3 = 1'b1;
    step(1);
    start3 = 1'b0;
    step(2);
    start3 = 1'b1;
    step(1);
    start3 = 1'b0;
    drain("start37");
    step(12);

    // start with din change: single conversion
    q3.push_back(mk(12'h050, 1'b0, 3'b100));
    din3   = 8'd50;
    start3 = 1'b1;
    step(1);
    start3 = 1'b0;
    drain("start50");
    step(12);

    // toggle away and back while busy
    q3.push_back(mk(12'h060, 1'b0, 3'b100));
    din3 = 8'd60;
    step(3);
    din3 = 8'd61;
    step(2);
    din3 = 8'd60;
    drain("60");
    step(12);

    // blanking vectors
    q3.push_back(mk(12'h007, 1'b0, 3'b110));
    din3 = 8'd7;
    drain("7");
    q3.push_back(mk(12'h000, 1'b0, 3'b110));
    din3 = 8'd0;
    drain("0");
    q3.push_back(mk(12'h105, 1'b0, 3'b000));
    din3 = 8'd105;
    drain("105");

    // reset mid-conversion
    din3 = 8'd200;
    step(4);
    resetn = 1'b0;
    @(negedge clock);
    chk_reset("midrst");
    step(2);
    q3.push_back(mk(12'h200, 1'b0, 3'b000));
    resetn = 1'b1;
    drain("200");
    step(12);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/out_port_bcd_conv.md
Name: out_port_bcd_conv

Overview:
- Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock) sitting downstream of the single-cycle CPU's output port.
- Watches the low DATA_W bits of out_port0 and re-converts whenever that value changes.
- Holds a stable, registered BCD digit vector that feeds one sevenseg decoder per digit.
- Output only changes when a conversion completes, so the display never shows intermediate values.

Parameters:
- DATA_W, 8, width of binary input; legal 4..32.
- DIGITS, 3, number of BCD digits produced; legal 1..10.

Ports:
- clock  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- din  in  DATA_W  binary value, normally out_port0[DATA_W-1:0]; need not be stable.
- start  in  1  force a re-conversion of din even if unchanged.
- bcd  out  4*DIGITS  registered BCD result; digit k at bits [4k+3:4k], k=0 least significant.
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse in the cycle bcd is updated.
- ovf  out  1  registered; 1 if the last converted value was >= 10^DIGITS.

Behaviour:
- Reset (asynchronous, resetn=0):
  - bcd=0, busy=0, done=0, ovf=0.
  - Internal last-value register=0, state=IDLE, shift/work registers=0.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - Trigger = start=1 or din != last.
  - On trigger: capture din into the shift register and into last, clear the BCD work register, count=DATA_W, go to SHIFT, busy=1 from the next cycle.
- SHIFT, once per cycle:
  - Every work digit >=5 gets +3.
  - Then {work, shift} shifts left by 1, count decrements.
  - After DATA_W SHIFT cycles, go to DONE.
- DONE:
  - Register the work digits into bcd, or saturate if ovf applies (see Arithmetic).
  - Update ovf, done=1 for this cycle only, busy=0 from the next cycle, return to IDLE.
- Latency: trigger cycle T; bcd and done valid at T+DATA_W+1; default DATA_W=8 gives 9 cycles.
- Back-to-back: a change already present in the IDLE cycle after DONE triggers immediately; worst-case throughput is one conversion per DATA_W+2 cycles.
- Arithmetic:
  - The work register is 4*DIGITS bits wide; bits shifted out of the top are discarded.
  - ovf is determined from the captured value compared against the constant 10^DIGITS (elaboration-time), not from the truncated work register.
  - When ovf=1, bcd saturates to all digits = 9.
- Boundary conditions:
  - din changes during SHIFT: ignored; the captured value completes. The new value differs from last, so it re-triggers after DONE.
  - start during SHIFT/DONE: ignored, not queued.
  - start and a din change in the same IDLE cycle: a single conversion of current din.
  - din toggling away and back to last within a busy period: no extra conversion.
  - resetn asserted mid-conversion: immediate abort, all outputs to reset values, no done pulse.
  - Initial state after reset: din=0 causes no conversion; bcd already correctly 0.
- busy and done are never high in the same cycle.

Optional Feature:
- Macro: OUT_PORT_BCD_BLANK_EN.
- Defined:
  - Adds output port blank (DIGITS bits), registered and updated in DONE together with bcd.
  - blank[k]=1 for each leading zero digit above the most significant nonzero digit; digit 0 is never blanked.
  - Reset value: all 0 except as reset value 0 (no blanking).
  - When ovf=1, blank=0.
- Not defined: port absent, no blanking logic; all other behaviour identical.

Test Plan:
- Reset, then din=8'd255 → busy=1 from next cycle; at trigger+9: bcd=12'h255, done pulse of 1 cycle, ovf=0; no further done while din holds.
- din=8'd99 then 8'd100 at trigger+3 → first done shows 12'h099; the second conversion starts the cycle after DONE, and the next done shows 12'h100.
- DIGITS=2, din=8'd100 → bcd=8'h99, ovf=1; then din=8'd42 → bcd=8'h42, ovf=0.
- din held at 8'd37, pulse start in IDLE → one conversion, bcd=12'h037, done pulse; start pulsed while busy → no additional done.
- resetn low at trigger+4 of din=8'd200 → bcd=0, busy=0, done never pulses; after release with din=200 → conversion runs, bcd=12'h200.
- With OUT_PORT_BCD_BLANK_EN:
  - din=8'd7 → blank=3'b110.
  - din=8'd0 → blank=3'b110.
  - din=8'd105 → blank=3'b000.
